mc_state_sequencer: RTL and testbench
=====================================

# mc_state_sequencer

Multi-cycle control state sequencer for the JAS multi-cycle CPU. It generates the 3-bit `state` code consumed by the instruction-parse control LUT and walks each instruction through IF, ID, EXEC, MEM and WB. Each opcode/funct takes its own path, and the sequencer stalls on a memory-ready handshake. It sits directly upstream of the control LUT and also provides retire and illegal-instruction indications plus a retired-instruction counter.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk`  in  1  rising-edge system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `opcode`  in  6  IR[31:26]; valid from the first ID cycle onward.
- `funct`  in  6  IR[5:0]; valid from the first ID cycle onward.
- `mem_ready`  in  1  memory handshake; the current IF or LW/SW MEM access completes on this cycle.
- `state`  out  3  state code: ID=0, IF=1, EXEC=2, MEM=3, WB=4.
- `instr_done`  out  1  high in the final state cycle of an instruction when that state advances to IF.
- `illegal`  out  1  one-cycle pulse in ID when opcode/funct is not supported.
- `retired`  out  CNT_W  count of completed instructions, including illegal ones; wraps modulo 2^CNT_W.

## Operation
- State register: 3 bits. Only codes 0–4 are legal; codes 5–7 go to IF on the next edge.
- IF: hold while `mem_ready`=0. When `mem_ready`=1, go to ID.
- ID: decode the live `opcode`/`funct`. Copy them into internal `op_q`/`fn_q` on the edge that leaves ID. EXEC onward uses only `op_q`/`fn_q`.
- Per-instruction paths (all start with IF, ID):
  - LW 100011: EXEC, MEM, WB.
  - SW 101011: EXEC, MEM.
  - J 000010: ends after ID.
  - JAL 000011: EXEC, MEM.
  - BEQ 000100 / BNE 000101: EXEC, MEM, WB.
  - ADDI 001000 / XORI 001110: EXEC, WB.
  - R-type 000000 with funct 100000/100010/101010: EXEC, WB.
  - R-type 000000 with funct JR 001000: EXEC only.
  - Any other opcode, or an unsupported R-type funct: `illegal`=1 in ID, then go to IF.
- MEM for LW/SW holds while `mem_ready`=0. MEM for JAL/BEQ/BNE does not wait and always lasts 1 cycle.
- WB always lasts 1 cycle.
- `instr_done` is combinational from the state register, `op_q`/`fn_q`, the live opcode/funct in ID, and `mem_ready`. It is high exactly in the cycle that transitions to IF: an instruction's final state, or ID for J or an illegal instruction.
- `retired` increments on every edge where `instr_done`=1.

## Timing
- Reset (async assert, sampled release):
  - `state`=IF (3'd1), `retired`=0, `op_q`=0, `fn_q`=0.
  - `instr_done`=0 and `illegal`=0, given `mem_ready`=0.
- First IF after reset release follows the normal IF rules.
- Cycle counts with `mem_ready` constantly 1:
  - LW: 5. BEQ/BNE: 5.
  - SW, JAL: 4. R-type ALU, ADDI/XORI: 4.
  - JR: 3. J: 2. Illegal: 2.
- Each `mem_ready`=0 cycle in IF or LW/SW MEM adds exactly one cycle.
- `mem_ready` is ignored in ID, EXEC, WB and non-memory MEM.
- Changes to `opcode`/`funct` after ID have no effect.
- Reset asserted mid-instruction: `state` goes to IF immediately, asynchronously, with no `instr_done`. `retired` clears.
- `retired` at all-ones plus a retire wraps to 0.
- `illegal` and `instr_done` are both high in the same ID cycle for an illegal instruction.

## Test plan
- Reset, then LW (opcode 100011), `mem_ready`=1 throughout -> state 1,0,2,3,4,1. `instr_done` high only in the WB cycle. `retired`=1.
- SW with `mem_ready` low for 2 cycles in MEM -> state 1,0,2,3,3,3,1. `instr_done` only in the third MEM cycle.
- J, then R-type funct 001000 (JR), back-to-back -> state 1,0,1,0,2,1. `retired`=2.
- Opcode 111111 -> `illegal` pulses in ID. State 1,0,1. `retired` increments by 1.
- BEQ with `opcode` changed to 000010 during EXEC -> full 5-cycle path still taken (latched `op_q`).
- Reset asserted during LW MEM -> `state`=1 within the same cycle and `retired`=0. After release, ADDI completes in 4 cycles.

Source files
------------

// File: rtl/mc_state_sequencer_if.sv
// rtl/mc_state_sequencer_if.sv - Decode, memory handshake and status bundle for the state sequencer
interface mc_state_sequencer_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             mem_ready;
    logic [2:0]       state;
    logic             instr_done;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        output opcode, funct, mem_ready,
        input  state, instr_done, illegal, retired
    );

    modport slave (
        input  opcode, funct, mem_ready,
        output state, instr_done, illegal, retired
    );
endinterface

// File: rtl/mc_state_sequencer.sv
// rtl/mc_state_sequencer.sv - Multi-cycle IF/ID/EXEC/MEM/WB control state sequencer
module mc_state_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    mc_state_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        ST_ID   = 3'd0,
        ST_IF   = 3'd1,
        ST_EXEC = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4
    } state_t;

    // Which sequence of post-ID states an instruction walks through.
    typedef enum logic [2:0] {
        P_LW, P_SW, P_J, P_JAL, P_BR, P_ALU, P_JR, P_ILL
    } path_t;

    function automatic path_t classify(input logic [5:0] op, input logic [5:0] fn);
        path_t p;
        case (op)
            6'b100011: p = P_LW;
            6'b101011: p = P_SW;
            6'b000010: p = P_J;
            6'b000011: p = P_JAL;
            6'b000100,
            6'b000101: p = P_BR;
            6'b001000,
            6'b001110: p = P_ALU;
            6'b000000: begin
                case (fn)
                    6'b100000,
                    6'b100010,
                    6'b101010: p = P_ALU;
                    6'b001000: p = P_JR;
                    default:   p = P_ILL;
                endcase
            end
            default:   p = P_ILL;
        endcase
        return p;
    endfunction

    state_t           state_q;
    logic [5:0]       op_q;
    logic [5:0]       fn_q;
    logic [CNT_W-1:0] retired_q;
    path_t            live_path;
    path_t            held_path;
    logic             done;

    // ID decodes the live IR fields; later states only trust the copy taken when leaving ID.
    assign live_path = classify(bus.opcode, bus.funct);
    assign held_path = classify(op_q, fn_q);

    // Flag the cycle whose edge returns the sequencer to IF.
    always_comb begin
        done = 1'b0;
        case (state_q)
            ST_ID:   done = (live_path == P_J) || (live_path == P_ILL);
            ST_EXEC: done = (held_path == P_JR);
            ST_MEM:  done = (held_path == P_JAL) || ((held_path == P_SW) && bus.mem_ready);
            ST_WB:   done = 1'b1;
            default: done = 1'b0;
        endcase
    end

    // State walk, IR field capture and retire counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IF;
            op_q      <= '0;
            fn_q      <= '0;
            retired_q <= '0;
        end else begin
            if (done) begin
                retired_q <= retired_q + CNT_W'(1);
            end
            case (state_q)
                ST_IF: begin
                    if (bus.mem_ready) begin
                        state_q <= ST_ID;
                    end
                end
                ST_ID: begin
                    op_q    <= bus.opcode;
                    fn_q    <= bus.funct;
                    state_q <= ((live_path == P_J) || (live_path == P_ILL)) ? ST_IF : ST_EXEC;
                end
                ST_EXEC: begin
                    case (held_path)
                        P_LW, P_SW, P_JAL, P_BR: state_q <= ST_MEM;
                        P_ALU:                   state_q <= ST_WB;
                        default:                 state_q <= ST_IF;
                    endcase
                end
                ST_MEM: begin
                    case (held_path)
                        P_LW:    if (bus.mem_ready) state_q <= ST_WB;
                        P_SW:    if (bus.mem_ready) state_q <= ST_IF;
                        P_BR:    state_q <= ST_WB;
                        default: state_q <= ST_IF;
                    endcase
                end
                ST_WB:   state_q <= ST_IF;
                default: state_q <= ST_IF;
            endcase
        end
    end

    assign bus.state      = state_q;
    assign bus.instr_done = done;
    assign bus.illegal    = (state_q == ST_ID) && (live_path == P_ILL);
    assign bus.retired    = retired_q;
endmodule

// File: tb/tb_mc_state_sequencer.sv
// tb/tb_mc_state_sequencer.sv - Randomized self-checking bench for mc_state_sequencer
module tb_mc_state_sequencer;
    localparam int CNT_W = 4;
    localparam int CNT_MOD = 1 << CNT_W;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mc_state_sequencer_if #(.CNT_W(CNT_W)) bus ();
    mc_state_sequencer #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: the current instruction as a list of (state code, waits-for-memory) phases.
    int         ph_code[6];
    bit         ph_wait[6];
    int         ph_len;
    bit         ph_ill;
    int         pos;
    logic [5:0] cur_op;
    logic [5:0] cur_fn;
    int         exp_ret;
    bit         junk_fixed;
    logic [5:0] junk_op;
    logic [5:0] pend_op[$];
    logic [5:0] pend_fn[$];

    logic [5:0] ops[9] = '{6'h23, 6'h2b, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0e, 6'h00};
    logic [5:0] fns[4] = '{6'h20, 6'h22, 6'h2a, 6'h08};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic add_phase(input int code, input bit wt);
        ph_code[ph_len] = code;
        ph_wait[ph_len] = wt;
        ph_len++;
    endtask

    task automatic load_instr(input logic [5:0] op, input logic [5:0] fn);
        cur_op = op;
        cur_fn = fn;
        pos    = 0;
        ph_ill = 1'b0;
        ph_len = 0;
        add_phase(1, 1'b1);
        add_phase(0, 1'b0);
        case (op)
            6'h23: begin add_phase(2, 0); add_phase(3, 1); add_phase(4, 0); end
            6'h2b: begin add_phase(2, 0); add_phase(3, 1); end
            6'h02: ;
            6'h03: begin add_phase(2, 0); add_phase(3, 0); end
            6'h04, 6'h05: begin add_phase(2, 0); add_phase(3, 0); add_phase(4, 0); end
            6'h08, 6'h0e: begin add_phase(2, 0); add_phase(4, 0); end
            6'h00: begin
                if (fn == 6'h20 || fn == 6'h22 || fn == 6'h2a) begin
                    add_phase(2, 0); add_phase(4, 0);
                end else if (fn == 6'h08) begin
                    add_phase(2, 0);
                end else begin
                    ph_ill = 1'b1;
                end
            end
            default: ph_ill = 1'b1;
        endcase
    endtask

    task automatic next_instr();
        logic [5:0] op;
        logic [5:0] fn;
        if (pend_op.size() > 0) begin
            op = pend_op.pop_front();
            fn = pend_fn.pop_front();
        end else begin
            int r;
            r = $urandom_range(0, 10);
            op = (r < 9) ? ops[r] : 6'($urandom);
            fn = ($urandom_range(0, 4) < 4) ? fns[$urandom_range(0, 3)] : 6'($urandom);
        end
        load_instr(op, fn);
    endtask

    // One clock: drive at posedge+1, check at negedge, advance the model at posedge.
    task automatic step(input logic mr, output bit saw_done);
        bit exp_done;
        bit exp_ill;
        bus.mem_ready = mr;
        if (ph_code[pos] == 0) begin
            bus.opcode = cur_op;
            bus.funct  = cur_fn;
        end else begin
            bus.opcode = junk_fixed ? junk_op : 6'($urandom);
            bus.funct  = 6'($urandom);
        end
        @(negedge clk);
        exp_done = (pos == ph_len - 1) && (!ph_wait[pos] || mr);
        exp_ill  = ph_ill && (ph_code[pos] == 0);
        saw_done = bus.instr_done;
        check_eq("state", 32'(bus.state), 32'(ph_code[pos]));
        check_eq("instr_done", 32'(bus.instr_done), 32'(exp_done));
        check_eq("illegal", 32'(bus.illegal), 32'(exp_ill));
        check_eq("retired", 32'(bus.retired), 32'(exp_ret));
        @(posedge clk);
        if (exp_done) begin
            exp_ret = (exp_ret + 1) % CNT_MOD;
            next_instr();
        end else if (!ph_wait[pos] || mr) begin
            pos++;
        end
        #1;
    endtask

    // Asynchronous assertion mid-cycle, release one edge later away from the edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        check_eq("rst_state", 32'(bus.state), 32'd1);
        check_eq("rst_retired", 32'(bus.retired), 32'd0);
        check_eq("rst_instr_done", 32'(bus.instr_done), 32'd0);
        check_eq("rst_illegal", 32'(bus.illegal), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_ret = 0;
    endtask

    task automatic run_count(input logic [5:0] op, input logic [5:0] fn, input int exp_n, input string tag);
        int n;
        bit d;
        load_instr(op, fn);
        n = 0;
        d = 1'b0;
        while (!d && n < 20) begin
            step(1'b1, d);
            n++;
        end
        check_eq(tag, 32'(n), 32'(exp_n));
    endtask

    initial begin
        bit d;
        logic dir_mr[$];
        int guard;
        rst_n = 1'b0;
        bus.mem_ready = 1'b0;
        bus.opcode = '0;
        bus.funct = '0;
        exp_ret = 0;
        junk_fixed = 1'b0;
        junk_op = '0;
        @(posedge clk);
        #1;
        do_reset();

        // Directed: LW, SW with MEM stall, J + JR, illegal, BEQ with opcode corrupted after ID.
        load_instr(6'h23, 6'h00);
        pend_op = '{6'h2b, 6'h02, 6'h00, 6'h3f, 6'h04};
        pend_fn = '{6'h00, 6'h00, 6'h08, 6'h00, 6'h00};
        dir_mr = '{1, 1, 1, 1, 1,
                   1, 1, 1, 0, 0, 1,
                   1, 1,
                   1, 1, 1,
                   1, 1,
                   1, 1, 1, 1, 1};
        junk_fixed = 1'b1;
        junk_op = 6'h02;
        while (dir_mr.size() > 0) begin
            step(dir_mr.pop_front(), d);
        end
        junk_fixed = 1'b0;

        // Randomized traffic with random memory stalls; retire count wraps repeatedly.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, d);
        end

        // Reset in the middle of an LW MEM stall, then ADDI from a clean start.
        pend_op = '{6'h23};
        pend_fn = '{6'h00};
        guard = 0;
        while (!(pend_op.size() == 0 && cur_op == 6'h23 && pos == 3) && guard < 200) begin
            step(1'b1, d);
            guard++;
        end
        check_eq("reach_lw_mem", 32'(guard < 200), 32'd1);
        do_reset();
        run_count(6'h08, 6'h00, 4, "cyc_addi_after_rst");

        // Path lengths with memory always ready.
        do_reset(); run_count(6'h23, 6'h00, 5, "cyc_lw");
        do_reset(); run_count(6'h04, 6'h00, 5, "cyc_beq");
        do_reset(); run_count(6'h05, 6'h00, 5, "cyc_bne");
        do_reset(); run_count(6'h2b, 6'h00, 4, "cyc_sw");
        do_reset(); run_count(6'h03, 6'h00, 4, "cyc_jal");
        do_reset(); run_count(6'h00, 6'h22, 4, "cyc_rtype");
        do_reset(); run_count(6'h0e, 6'h00, 4, "cyc_xori");
        do_reset(); run_count(6'h00, 6'h08, 3, "cyc_jr");
        do_reset(); run_count(6'h02, 6'h00, 2, "cyc_j");
        do_reset(); run_count(6'h00, 6'h01, 2, "cyc_ill_funct");
        do_reset(); run_count(6'h3f, 6'h00, 2, "cyc_ill_op");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
